// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 convolution window generator.
package conv_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int WIN_TAPS       = 9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Flattened tap index: r=0 is the oldest row, c=0 the leftmost column.
    function automatic int win_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage: combinational read, synchronous write at the same address.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The read sees the old word in the same cycle it is overwritten.
    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Turns a raster-order pixel stream into every fully populated 3x3 window of the frame.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [DATA_W-1:0]          pix_in,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    output logic [WIN_TAPS*DATA_W-1:0] win,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic                       frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_t state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic [DATA_W-1:0] new_col [3];
    logic [WIN_TAPS*DATA_W-1:0] win_nxt;
    logic accept, out_fire, qualify, last_pix, out_free;

    assign out_free = !win_valid || win_ready;
    assign accept   = pix_valid && pix_ready;
    assign out_fire = win_valid && win_ready;
    assign qualify  = (row >= ROW_TWO) && (col >= COL_TWO);
    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (pix_in),
        .rdata (lb1_rd)
    );

    conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) lb2 (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (lb1_rd),
        .rdata (lb2_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (accept && last_pix) state_nxt = DRAIN;
            DRAIN:   if (out_free) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pix_ready  = (state == RUN) && out_free;
        frame_done = (state == DRAIN) && out_free;
    end

    // The last pixel wraps both counters, so row is already zero on entry to DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign new_col[0] = lb2_rd;
    assign new_col[1] = lb1_rd;
    assign new_col[2] = pix_in;

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 2; c++) begin : g_shift
            assign win_nxt[win_idx(r, c)*DATA_W +: DATA_W] = win[win_idx(r, c + 1)*DATA_W +: DATA_W];
        end
        assign win_nxt[win_idx(r, 2)*DATA_W +: DATA_W] = new_col[r];
    end

    // Taps shift on every accept; stale columns after a row wrap are masked by the col>=2 gate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win       <= '0;
            win_valid <= 1'b0;
        end else begin
            if (accept) begin
                win <= win_nxt;
            end
            if (accept && qualify) begin
                win_valid <= 1'b1;
            end else if (out_fire) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: table of randomized frames plus hand-written corner sequences.
module tb_conv_window_gen;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int WW     = 9 * DATA_W;

    logic              clk = 1'b0;
    logic              rst, en, pix_valid, pix_ready;
    logic              win_valid, win_ready, frame_done;
    logic [DATA_W-1:0] pix_in;
    logic [WW-1:0]     win;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int base;
        bit rand_pix;
        int vpct;
        int rpct;
        int stall;
        int exp_windows;
        int exp_done;
    } vec_t;

    vec_t              vecs [5];
    logic [WW-1:0]     exp_q [$];
    logic [DATA_W-1:0] img [NPIX];

    always #5 clk = ~clk;

    conv_window_gen #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win        (win),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .frame_done (frame_done)
    );

    task automatic check_output(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Reference: every window whose top-left corner leaves room for a full 3x3 block.
    task automatic build_frame(input int base, input bit rand_pix);
        logic [WW-1:0] w;
        exp_q.delete();
        for (int p = 0; p < NPIX; p++) begin
            img[p] = rand_pix ? DATA_W'($urandom) : DATA_W'(base + p);
        end
        for (int r = 0; r <= IMG_H - 3; r++) begin
            for (int c = 0; c <= IMG_W - 3; c++) begin
                w = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        w[(3*i + j)*DATA_W +: DATA_W] = img[(r + i)*IMG_W + c + j];
                    end
                end
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic apply_stimulus(input int vpct, input int rpct, input int stall, input bit hold_en,
                                  input int stop_after, output int wins, output int dones, output int first_acc);
        int  idx = 0;
        int  cyc = 0;
        int  acc_cyc = -1;
        int  first_win = -1;
        int  stall_left = stall;
        bit  done = 0;
        wins = 0;
        dones = 0;
        first_acc = -1;
        en = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (!hold_en && idx > 0) en = 1'b0;
            pix_valid = (idx < NPIX) && (int'($urandom_range(99)) < vpct);
            pix_in    = (idx < NPIX) ? img[idx] : '0;
            if (win_valid && stall_left > 0) begin
                win_ready = 1'b0;
                stall_left--;
            end else begin
                win_ready = int'($urandom_range(99)) < rpct;
            end
            #1;
            if (win_valid && first_win < 0) begin
                first_win = cyc;
                check_int("first_window_latency", first_win - acc_cyc, 1);
            end
            if (win_valid && !win_ready) begin
                check_bit("stall_pix_ready", pix_ready, 1'b0);
                if (exp_q.size() == 0) check_int("unexpected_window", 1, 0);
                else check_output("stall_win", win, exp_q[0]);
            end
            if (win_valid && win_ready) begin
                wins++;
                if (exp_q.size() == 0) check_int("extra_window", 1, 0);
                else check_output($sformatf("window%0d", wins), win, exp_q.pop_front());
            end
            if (frame_done) begin
                dones++;
                check_int("queue_empty_at_done", exp_q.size(), 0);
                done = 1;
            end
            if (pix_valid && pix_ready) begin
                if (first_acc < 0) first_acc = cyc;
                if (idx == 2*IMG_W + 2) acc_cyc = cyc;
                idx++;
                if (stop_after >= 0 && idx >= stop_after) done = 1;
            end
            cyc++;
            if (cyc > 2000) begin
                check_int("frame_timeout", cyc, 2000);
                done = 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        pix_valid = 1'b0;
        #1;
        check_bit("rst_pix_ready", pix_ready, 1'b0);
        check_bit("rst_win_valid", win_valid, 1'b0);
        check_bit("rst_frame_done", frame_done, 1'b0);
        check_output("rst_win", win, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int wins, dones, first_acc, total_w, total_d;

        vecs[0] = '{base: 0,  rand_pix: 0, vpct: 100, rpct: 100, stall: 0, exp_windows: 4, exp_done: 1};
        vecs[1] = '{base: 0,  rand_pix: 0, vpct: 100, rpct: 100, stall: 6, exp_windows: 4, exp_done: 1};
        vecs[2] = '{base: 0,  rand_pix: 0, vpct: 50,  rpct: 100, stall: 0, exp_windows: 4, exp_done: 1};
        vecs[3] = '{base: 0,  rand_pix: 1, vpct: 70,  rpct: 60,  stall: 0, exp_windows: 4, exp_done: 1};
        vecs[4] = '{base: 0,  rand_pix: 1, vpct: 100, rpct: 30,  stall: 3, exp_windows: 4, exp_done: 1};

        rst = 1'b1;
        en = 1'b0;
        pix_valid = 1'b0;
        pix_in = '0;
        win_ready = 1'b0;
        do_reset();

        for (int t = 0; t < 5; t++) begin
            build_frame(vecs[t].base, vecs[t].rand_pix);
            apply_stimulus(vecs[t].vpct, vecs[t].rpct, vecs[t].stall, 1'b0, -1, wins, dones, first_acc);
            check_int($sformatf("vec%0d_windows", t), wins, vecs[t].exp_windows);
            check_int($sformatf("vec%0d_frame_done", t), dones, vecs[t].exp_done);
            repeat (3) @(negedge clk);
        end

        // Idle with en low: nothing may be accepted or produced.
        do_reset();
        pix_valid = 1'b1;
        win_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check_bit("idle_pix_ready", pix_ready, 1'b0);
            check_bit("idle_win_valid", win_valid, 1'b0);
        end
        pix_valid = 1'b0;
        build_frame(0, 1'b0);
        apply_stimulus(100, 100, 0, 1'b0, -1, wins, dones, first_acc);
        check_int("after_idle_windows", wins, 4);

        // Reset after pixel 9, then a clean frame.
        build_frame(0, 1'b0);
        apply_stimulus(100, 100, 0, 1'b0, 10, wins, dones, first_acc);
        do_reset();
        build_frame(0, 1'b0);
        apply_stimulus(100, 100, 0, 1'b0, -1, wins, dones, first_acc);
        check_int("after_reset_windows", wins, 4);
        check_int("after_reset_done", dones, 1);

        // Back-to-back frames with en held high.
        repeat (2) @(negedge clk);
        build_frame(0, 1'b0);
        apply_stimulus(100, 100, 0, 1'b1, -1, wins, dones, first_acc);
        total_w = wins;
        total_d = dones;
        build_frame(100, 1'b0);
        check_output("b2b_first_window_model", exp_q[0],
                     {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100});
        apply_stimulus(100, 100, 0, 1'b0, -1, wins, dones, first_acc);
        check_int("b2b_restart_cycle", first_acc, 1);
        total_w += wins;
        total_d += dones;
        check_int("b2b_windows", total_w, 8);
        check_int("b2b_frame_done", total_d, 2);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
